// File: rtl/matrix_ctrl_pkg.sv
// Shared definitions for the binary-image 3x3 window flow controller:
// FSM encoding, coordinate width and parameter defaults.
package matrix_ctrl_pkg;

  localparam int unsigned COORD_W      = 12;
  localparam int unsigned DEF_IMG_W    = 1600;
  localparam int unsigned DEF_IMG_H    = 1200;
  localparam int unsigned DEF_PIPE_LAT = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_window_ctrl_if.sv
// Pixel-in / window-tag-out bundle of matrix_window_ctrl.
// The master side is the pixel source; the slave side is the controller.
interface matrix_window_ctrl_if;
  import matrix_ctrl_pkg::*;

  logic   frame_start;
  logic   pix_valid;
  logic   pix_bit;
  logic   wr_en;
  logic   img_1bit;
  logic   win_valid;
  coord_t win_col;
  coord_t win_row;
  logic   frame_done;
  logic   busy;
  logic   err_overrun;

  modport master (
    output frame_start, pix_valid, pix_bit,
    input  wr_en, img_1bit, win_valid, win_col, win_row,
    input  frame_done, busy, err_overrun
  );

  modport slave (
    input  frame_start, pix_valid, pix_bit,
    output wr_en, img_1bit, win_valid, win_col, win_row,
    output frame_done, busy, err_overrun
  );

endinterface

// File: rtl/win_tag_delay.sv
// Flushable shift-register delay for window tags {valid, col, row}.
// The last stage is the registered output; o_pending flags tags still in flight behind it.
module win_tag_delay
  import matrix_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_PIPE_LAT + 1
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_flush,
  input  logic   i_vld,
  input  coord_t i_col,
  input  coord_t i_row,
  output logic   o_vld,
  output coord_t o_col,
  output coord_t o_row,
  output logic   o_pending
);

  logic   r_vld [DEPTH];
  coord_t r_col [DEPTH];
  coord_t r_row [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_vld[k] <= 1'b0;
        r_col[k] <= '0;
        r_row[k] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      r_col[0] <= i_col;
      r_row[0] <= i_row;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_col[k] <= r_col[k-1];
        r_row[k] <= r_row[k-1];
      end
    end
  end

  always_comb begin
    o_pending = 1'b0;
    for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
      o_pending = o_pending | r_vld[k];
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_col = r_col[DEPTH-1];
  assign o_row = r_row[DEPTH-1];

endmodule

// File: rtl/matrix_window_ctrl.sv
// Frame sequencing and flow control in front of a 3x3 binary matrix generator:
// forwards accepted pixels, tags complete windows and aligns the tags with the generator latency.
module matrix_window_ctrl
  import matrix_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W    = DEF_IMG_W,
  parameter int unsigned IMG_H    = DEF_IMG_H,
  parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  matrix_window_ctrl_if.slave bus
);

  localparam coord_t LP_COL_MAX = coord_t'(IMG_W - 1);
  localparam coord_t LP_ROW_MAX = coord_t'(IMG_H - 1);
  localparam coord_t LP_ONE     = coord_t'(1);
  localparam coord_t LP_TWO     = coord_t'(2);

  state_t r_state;
  coord_t r_col;
  coord_t r_row;
  logic   r_wr_en;
  logic   r_img;
  logic   r_done;
  logic   r_busy;
  logic   r_err;

  logic   w_active;
  logic   w_accept;
  logic   w_err_new;
  coord_t w_col;
  coord_t w_row;
  logic   w_last_col;
  logic   w_last_pix;
  logic   w_tag_vld;
  coord_t w_tag_col;
  coord_t w_tag_row;
  logic   w_dly_vld;
  coord_t w_dly_col;
  coord_t w_dly_row;
  logic   w_dly_pending;
  logic   w_drain_done;

  assign w_active  = (r_state == ST_PRIME) || (r_state == ST_RUN);
  // A restart accepts its own pixel as (0,0), so coordinates come from a zeroed counter.
  assign w_accept  = bus.pix_valid && (bus.frame_start || w_active);
  assign w_err_new = bus.pix_valid && !bus.frame_start && !w_active;
  assign w_col     = bus.frame_start ? '0 : r_col;
  assign w_row     = bus.frame_start ? '0 : r_row;

  assign w_last_col = (w_col == LP_COL_MAX);
  assign w_last_pix = w_last_col && (w_row == LP_ROW_MAX);
  assign w_tag_vld  = w_accept && (w_col >= LP_TWO) && (w_row >= LP_TWO);
  assign w_tag_col  = w_tag_vld ? (w_col - LP_ONE) : '0;
  assign w_tag_row  = w_tag_vld ? (w_row - LP_ONE) : '0;

  // The frame's final pixel always completes a window, so DRAIN ends when that tag is at the output.
  assign w_drain_done = (r_state == ST_DRAIN) && !bus.frame_start && w_dly_vld && !w_dly_pending;

  win_tag_delay #(
    .DEPTH(PIPE_LAT + 1)
  ) u_win_tag_delay (
    .i_clk     (sys_clk),
    .i_rst_n   (sys_rst_n),
    .i_flush   (bus.frame_start),
    .i_vld     (w_tag_vld),
    .i_col     (w_tag_col),
    .i_row     (w_tag_row),
    .o_vld     (w_dly_vld),
    .o_col     (w_dly_col),
    .o_row     (w_dly_row),
    .o_pending (w_dly_pending)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_wr_en <= 1'b0;
      r_img   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) r_img <= bus.pix_bit;
      r_done <= w_drain_done;
      r_err  <= bus.frame_start ? w_err_new : (r_err | w_err_new);

      if (w_accept) begin
        r_col <= w_last_col ? '0 : (w_col + LP_ONE);
        r_row <= w_last_col ? (w_row + LP_ONE) : w_row;
      end else if (bus.frame_start) begin
        r_col <= '0;
        r_row <= '0;
      end

      if (bus.frame_start) begin
        r_state <= ST_PRIME;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_PRIME: begin
            if (w_accept) begin
              if (w_last_pix) r_state <= ST_DRAIN;
              else if ((w_col == LP_TWO) && (w_row == LP_TWO)) r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_accept && w_last_pix) r_state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            if (w_drain_done) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_en       = r_wr_en;
  assign bus.img_1bit    = r_img;
  assign bus.win_valid   = w_dly_vld;
  assign bus.win_col     = w_dly_col;
  assign bus.win_row     = w_dly_row;
  assign bus.frame_done  = r_done;
  assign bus.busy        = r_busy;
  assign bus.err_overrun = r_err;

endmodule

// File: doc/matrix_window_ctrl.md
MATRIX_WINDOW_CTRL -- requirements
Module: matrix_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 1600, pixels per line (3..4095).
REQ-002 SHALL have parameter IMG_H, default 1200, lines per frame (3..4095).
REQ-003 SHALL have parameter PIPE_LAT, default 4, cycles from wr_en to an updated 3x3 window at the matrix generator outputs (1..15).
REQ-004 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-006 frame_start  input  1  one-cycle pulse; arms or restarts frame sequencing.
REQ-007 pix_valid  input  1  incoming binary pixel qualifier.
REQ-008 pix_bit  input  1  incoming binary pixel.
REQ-009 wr_en  output  1  pixel write strobe to the 3x3 matrix generator.
REQ-010 img_1bit  output  1  pixel to the matrix generator, registered with wr_en.
REQ-011 win_valid  output  1  generator window is complete (no border pixels); aligned with the updated matrix.
REQ-012 win_col  output  12  window centre column, valid with win_valid.
REQ-013 win_row  output  12  window centre row, valid with win_valid.
REQ-014 frame_done  output  1  one-cycle pulse after the last window of a frame.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 err_overrun  output  1  sticky protocol-error flag.

Function
REQ-017 FSM states: IDLE, PRIME, RUN, DRAIN.
REQ-018 IDLE -> PRIME on frame_start; col/row counters cleared to 0.
REQ-019 In PRIME/RUN, each pix_valid cycle: wr_en=1 and img_1bit=pix_bit on the next cycle (1-cycle latency); col increments.
REQ-020 Col wraps IMG_W-1 -> 0 with row increment; both 12-bit unsigned, no other wrap.
REQ-021 PRIME -> RUN when the pixel at (col=2,row=2) is accepted.
REQ-022 Accepted pixel with col>=2 and row>=2 tags a window with centre (col-1,row-1).
REQ-023 Window tag SHALL be delayed by PIPE_LAT+1 cycles from pixel acceptance, then drive win_valid/win_col/win_row for one cycle.
REQ-024 Acceptance of (IMG_W-1,IMG_H-1): -> DRAIN; pix_valid then ignored.
REQ-025 DRAIN lasts until the delay line is empty; frame_done pulses on the cycle after the last win_valid, with a same-cycle transition to IDLE.
REQ-026 pix_valid in IDLE or DRAIN: pixel dropped, no wr_en, err_overrun set.
REQ-027 frame_start in PRIME/RUN/DRAIN aborts: counters cleared, delay line flushed (pending win_valid suppressed), no frame_done, -> PRIME.
REQ-028 frame_start with pix_valid in the same cycle: restart takes priority; that pixel is accepted as (0,0).
REQ-029 err_overrun is cleared only by frame_start or reset; frame_start and a new error in the same cycle leave err_overrun=1.
REQ-030 wr_en never asserts without an accepted pixel; wr_en count per complete frame = IMG_W*IMG_H.

Reset
REQ-031 With sys_rst_n=0 at a clock edge: state=IDLE; wr_en, img_1bit, win_valid, frame_done, busy, err_overrun=0; win_col, win_row=0; counters and delay line cleared.
REQ-032 Reset mid-frame SHALL discard all pending windows; no frame_done SHALL follow.

Structure
REQ-033 Shared package matrix_ctrl_pkg SHALL hold the FSM state encoding, the 12-bit coordinate width constant and the defaults for IMG_W/IMG_H/PIPE_LAT.
REQ-034 The delay of {valid,col,row} SHALL be the sub-module win_tag_delay (parameterised depth, flushable, synchronous reset).
REQ-035 Flow control is the sole responsibility of this block; the matrix generator is instantiated alongside it and not inside it.

Verification (IMG_W=8, IMG_H=4, PIPE_LAT=4)
REQ-036 frame_start, then 32 consecutive pix_valid -> 32 wr_en pulses; 12 win_valid; first centre (1,1); last centre (6,2); frame_done exactly once, 1 cycle after the last win_valid.
REQ-037 Same frame with pix_valid 1-of-3 duty -> identical win_valid count and coordinates; each win_valid 5 cycles after its accepted pixel.
REQ-038 pix_valid in IDLE, then frame_start -> err_overrun=1, no wr_en; cleared on frame_start.
REQ-039 frame_start after 20 pixels -> no further win_valid from the old frame; next 32 pixels produce a clean 12-window frame.
REQ-040 sys_rst_n=0 for 1 cycle during DRAIN -> all outputs 0, no frame_done, busy=0.
